// File: rtl/run_length_detector.sv
// run_length_detector
//   Tracks the current run of identical bits on the serial input w and flags
//   a zero-run reaching RUN0 or a one-run reaching RUN1.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low; clears all state including hit_cnt
//   en         sample enable; w and mode are consumed only when en=1
//   clear      synchronous FSM clear (active-high); hit_cnt is kept
//   w          serial input bit
//   mode       00 both runs, 01 zeros only, 10 ones only, 11 detection off
//   z          registered detection level
//   hit_pulse  one-cycle pulse per new detection
//   hit_cnt    saturating count of hit_pulse events
//   run_len    current run length, saturating at 2^CW-1
//   y          state code: 0 IDLE, 1 ZRUN, 2 ORUN
module run_length_detector #(
  parameter int RUN0 = 4,
  parameter int RUN1 = 4,
  parameter int CW   = 3,
  parameter int HCW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clear,
  input  logic           w,
  input  logic [1:0]     mode,
  output logic           z,
  output logic           hit_pulse,
  output logic [HCW-1:0] hit_cnt,
  output logic [CW-1:0]  run_len,
  output logic [1:0]     y
);

  localparam int SAT = (1 << CW) - 1;
  localparam logic [CW-1:0]  SAT_L  = CW'(SAT);
  localparam logic [HCW-1:0] HMAX_L = {HCW{1'b1}};
  localparam logic [CW-1:0]  TH0    = CW'(RUN0);
  localparam logic [CW-1:0]  TH1    = CW'(RUN1);
  localparam logic [CW-1:0]  LEN1   = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZRUN = 2'd1;
  localparam logic [1:0] ORUN = 2'd2;

  // Thresholds must be reachable by the saturating run_len counter.
  if (RUN0 < 1 || RUN0 > SAT) begin : g_bad_run0
    $error("run_length_detector: RUN0 must lie in [1, 2^CW-1]");
  end
  if (RUN1 < 1 || RUN1 > SAT) begin : g_bad_run1
    $error("run_length_detector: RUN1 must lie in [1, 2^CW-1]");
  end

  function automatic logic [CW-1:0] len_inc(input logic [CW-1:0] v);
    return (v == SAT_L) ? v : v + 1'b1;
  endfunction

  function automatic logic [HCW-1:0] cnt_inc(input logic [HCW-1:0] v);
    return (v == HMAX_L) ? v : v + 1'b1;
  endfunction

  logic [1:0]    state, state_nx;
  logic [CW-1:0] len_nx;
  logic          z_nx, hit_nx, at_th;

  // State register plus registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      run_len   <= '0;
      z         <= 1'b0;
      hit_pulse <= 1'b0;
      hit_cnt   <= '0;
    end else if (clear) begin
      state     <= IDLE;
      run_len   <= '0;
      z         <= 1'b0;
      hit_pulse <= 1'b0;
    end else if (en) begin
      state     <= state_nx;
      run_len   <= len_nx;
      z         <= z_nx;
      hit_pulse <= hit_nx;
      if (hit_nx) hit_cnt <= cnt_inc(hit_cnt);
    end else begin
      hit_pulse <= 1'b0;
      // The unused encoding falls back to IDLE even while sampling is paused.
      if (state != IDLE && state != ZRUN && state != ORUN) begin
        state   <= IDLE;
        run_len <= '0;
      end
    end
  end

  // Next-state / next-length
  always_comb begin
    state_nx = state;
    len_nx   = run_len;
    case (state)
      IDLE: begin
        state_nx = w ? ORUN : ZRUN;
        len_nx   = LEN1;
      end
      ZRUN: begin
        if (w) begin
          state_nx = ORUN;
          len_nx   = LEN1;
        end else begin
          len_nx   = len_inc(run_len);
        end
      end
      ORUN: begin
        if (!w) begin
          state_nx = ZRUN;
          len_nx   = LEN1;
        end else begin
          len_nx   = len_inc(run_len);
        end
      end
      default: begin
        state_nx = IDLE;
        len_nx   = '0;
      end
    endcase
  end

  // Detection outputs derived from the next state/length
  always_comb begin
    z_nx   = ((state_nx == ZRUN) && (len_nx >= TH0) && !mode[1]) ||
             ((state_nx == ORUN) && (len_nx >= TH1) && !mode[0]);
    // Exact-threshold hits count only when the run actually grew onto the
    // threshold; a run pinned at SAT with threshold SAT must not re-fire.
    at_th  = (((state_nx == ZRUN) && (len_nx == TH0)) ||
              ((state_nx == ORUN) && (len_nx == TH1))) &&
             !((state_nx == state) && (len_nx == run_len));
    hit_nx = z_nx && (at_th || !z);
  end

  assign y = state;

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clear = 1'b0;
  logic       w = 1'b0;
  logic [1:0] mode = 2'b00;

  logic       z_a, hp_a;
  logic [7:0] hc_a;
  logic [2:0] rl_a;
  logic [1:0] y_a;

  logic       z_b, hp_b;
  logic [1:0] hc_b;
  logic [2:0] rl_b;
  logic [1:0] y_b;

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  run_length_detector #(.RUN0(4), .RUN1(4), .CW(3), .HCW(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .w(w), .mode(mode),
    .z(z_a), .hit_pulse(hp_a), .hit_cnt(hc_a), .run_len(rl_a), .y(y_a));

  run_length_detector #(.RUN0(1), .RUN1(1), .CW(3), .HCW(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .w(w), .mode(mode),
    .z(z_b), .hit_pulse(hp_b), .hit_cnt(hc_b), .run_len(rl_b), .y(y_b));

  // Reference model: unbounded run counter, outputs derived from the rules.
  typedef struct {
    bit idle;
    bit cur;
    int cnt;
    bit z;
    bit hit;
    int hits;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, bit rst_n, bit clr, bit e, bit wi,
                                bit [1:0] md, int r0, int r1, int hmax);
    mdl_t n = m;
    int th;
    bit allowed, zn;
    if (!rst_n) begin
      n.idle = 1; n.cur = 0; n.cnt = 0; n.z = 0; n.hit = 0; n.hits = 0;
    end else if (clr) begin
      n.idle = 1; n.cnt = 0; n.z = 0; n.hit = 0;
    end else if (!e) begin
      n.hit = 0;
    end else begin
      if (m.idle || m.cur != wi) begin
        n.cnt = 1;
        n.cur = wi;
      end else begin
        n.cnt = m.cnt + 1;
      end
      n.idle  = 0;
      th      = wi ? r1 : r0;
      allowed = wi ? (md == 2'b00 || md == 2'b10) : (md == 2'b00 || md == 2'b01);
      zn      = allowed && (n.cnt >= th);
      n.hit   = zn && (n.cnt == th || !m.z);
      n.z     = zn;
      if (n.hit && n.hits < hmax) n.hits = n.hits + 1;
    end
    return n;
  endfunction

  function automatic int exp_len(mdl_t m);
    return m.idle ? 0 : ((m.cnt > 7) ? 7 : m.cnt);
  endfunction

  function automatic int exp_y(mdl_t m);
    return m.idle ? 0 : (m.cur ? 2 : 1);
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model update on every edge, then a full compare of both DUTs just after.
  always begin
    @(posedge clk);
    ma = step(ma, reset, clear, en, w, mode, 4, 4, 255);
    mb = step(mb, reset, clear, en, w, mode, 1, 1, 3);
    if (!reset) armed = 1;
    #1;
    if (armed) begin
      chk("a.z",       int'(z_a),  int'(ma.z));
      chk("a.hit",     int'(hp_a), int'(ma.hit));
      chk("a.hit_cnt", int'(hc_a), ma.hits);
      chk("a.run_len", int'(rl_a), exp_len(ma));
      chk("a.y",       int'(y_a),  exp_y(ma));
      chk("b.z",       int'(z_b),  int'(mb.z));
      chk("b.hit",     int'(hp_b), int'(mb.hit));
      chk("b.hit_cnt", int'(hc_b), mb.hits);
      chk("b.run_len", int'(rl_b), exp_len(mb));
      chk("b.y",       int'(y_b),  exp_y(mb));
    end
  end

  task automatic cyc(bit r, bit c, bit e, bit wi, bit [1:0] md);
    @(negedge clk);
    reset = r; clear = c; en = e; w = wi; mode = md;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_a(string nm, int len, int zz, int hp, int hc, int yy);
    chk({nm, ".len"}, int'(rl_a), len);
    chk({nm, ".z"},   int'(z_a),  zz);
    chk({nm, ".hp"},  int'(hp_a), hp);
    chk({nm, ".hc"},  int'(hc_a), hc);
    chk({nm, ".y"},   int'(y_a),  yy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lens[4];
    int zs[4];
    int bit_pat[5];
    int hcs[5];
    lens = '{1, 2, 3, 4};
    zs   = '{0, 0, 0, 1};
    bit_pat = '{0, 1, 0, 1, 0};
    hcs  = '{1, 2, 3, 3, 3};

    cyc(0, 0, 0, 0, 2'b00);
    cyc(0, 0, 0, 0, 2'b00);
    chk_a("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 0, 2'b00);
      chk_a("zrun", lens[i], zs[i], (i == 3) ? 1 : 0, (i == 3) ? 1 : 0, 1);
    end

    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 2'b00);
    chk_a("sat", 7, 1, 0, 1, 1);
    cyc(1, 0, 1, 1, 2'b00);
    chk_a("switch1", 1, 0, 0, 1, 2);

    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 2'b01);
    chk_a("zeros_only", 6, 0, 0, 1, 2);
    cyc(1, 0, 1, 1, 2'b00);
    chk_a("mode_enable", 7, 1, 1, 2, 2);

    cyc(1, 0, 1, 0, 2'b00);
    cyc(1, 0, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, i[0], 2'b00);
      chk_a("hold", 2, 0, 0, 2, 1);
    end
    cyc(1, 0, 1, 0, 2'b00);
    chk_a("resume3", 3, 0, 0, 2, 1);
    cyc(1, 0, 1, 0, 2'b00);
    chk_a("resume4", 4, 1, 1, 3, 1);

    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 2'b00);
    cyc(1, 1, 1, 1, 2'b00);
    chk_a("clear", 0, 0, 0, 3, 0);

    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 2'b11);
    chk_a("mode_off", 5, 0, 0, 3, 1);
    cyc(1, 0, 0, 1, 2'b00);
    chk_a("mode_no_en", 5, 0, 0, 3, 1);
    cyc(1, 0, 1, 0, 2'b00);
    chk_a("mode_on", 6, 1, 1, 4, 1);

    cyc(1, 0, 1, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    chk_a("reset_mid", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, bit_pat[i][0], 2'b00);
      chk("b.alt.z",  int'(z_b),  1);
      chk("b.alt.hp", int'(hp_b), 1);
      chk("b.alt.hc", int'(hc_b), hcs[i]);
      chk("b.alt.len", int'(rl_b), 1);
    end

    cyc(1, 0, 0, 0, 2'b00);
    cyc(1, 0, 0, 0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
